// File: rtl/pc_reg_if.sv
// Bus between the next-PC logic and the program-counter register.
interface pc_reg_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] next_pc;
  logic             enable;
  logic [WIDTH-1:0] curr_pc;

  modport master (
    output next_pc,
    output enable,
    input  curr_pc
  );

  modport slave (
    input  next_pc,
    input  enable,
    output curr_pc
  );
endinterface

// File: rtl/pc_reg.sv
// Program-counter register: loads next_pc when enabled, holds on stall.
`ifndef PC_ENABLED
`define PC_ENABLED 1'b1
`endif
`ifndef PC_DISABLED
`define PC_DISABLED 1'b0
`endif

module pc_reg #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic        clk,
   input  logic        rst_n,
   pc_reg_if.slave     pcBus
);

   logic [WIDTH-1:0] r_pc;

   // Reset outranks enable; the stored value is taken verbatim with no alignment masking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (pcBus.enable == `PC_ENABLED) begin
         r_pc <= pcBus.next_pc;
      end
   end

   assign pcBus.curr_pc = r_pc;

endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg with hand-computed expected PCs.
`ifndef PC_ENABLED
`define PC_ENABLED 1'b1
`endif
`ifndef PC_DISABLED
`define PC_DISABLED 1'b0
`endif

module tb_pc_reg;

   localparam int WIDTH = 32;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   failCount;

   pc_reg_if #(.WIDTH(WIDTH)) pcBus ();

   pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (32'h00000000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pcBus (pcBus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic applyStimulus(input logic rst, input logic en, input logic [WIDTH-1:0] npc);
      @(negedge clk);
      rst_n         = rst;
      pcBus.enable  = en;
      pcBus.next_pc = npc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount    = 0;
      failCount     = 0;
      rst_n         = 1'b0;
      pcBus.enable  = `PC_ENABLED;
      pcBus.next_pc = 32'hdeadbeef;

      applyStimulus(1'b0, `PC_ENABLED, 32'hdeadbeef);
      checkOutput("reset_first_edge", pcBus.curr_pc, 32'h00000000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, `PC_ENABLED, 32'hdeadbeef);
         checkOutput("reset_held", pcBus.curr_pc, 32'h00000000);
      end

      applyStimulus(1'b1, `PC_ENABLED, 32'h00000004);
      checkOutput("normal_update", pcBus.curr_pc, 32'h00000004);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, `PC_DISABLED, 32'hdeedbeef);
         checkOutput("hold_disabled", pcBus.curr_pc, 32'h00000004);
      end

      applyStimulus(1'b1, `PC_ENABLED, 32'h0000002a);
      checkOutput("unaligned_load", pcBus.curr_pc, 32'h0000002a);

      // Mid-cycle changes must not leak through; only the value at the edge counts.
      @(negedge clk);
      pcBus.next_pc = 32'h00000030;
      pcBus.enable  = `PC_ENABLED;
      #2;
      checkOutput("midcycle_no_leak_a", pcBus.curr_pc, 32'h0000002a);
      pcBus.next_pc = 32'h00000044;
      #2;
      checkOutput("midcycle_no_leak_b", pcBus.curr_pc, 32'h0000002a);
      @(posedge clk);
      #1;
      checkOutput("midcycle_edge_value", pcBus.curr_pc, 32'h00000044);

      applyStimulus(1'b1, `PC_ENABLED, 32'hffffffff);
      checkOutput("full_width_ones", pcBus.curr_pc, 32'hffffffff);
      applyStimulus(1'b1, `PC_ENABLED, 32'h0000002a);
      checkOutput("reload_2a", pcBus.curr_pc, 32'h0000002a);

      applyStimulus(1'b0, `PC_ENABLED, 32'h00000100);
      checkOutput("reset_priority", pcBus.curr_pc, 32'h00000000);
      applyStimulus(1'b0, `PC_DISABLED, 32'h00000200);
      checkOutput("reset_while_disabled", pcBus.curr_pc, 32'h00000000);
      applyStimulus(1'b1, `PC_ENABLED, 32'h00000100);
      checkOutput("reset_release_load", pcBus.curr_pc, 32'h00000100);
      applyStimulus(1'b1, `PC_DISABLED, 32'h12345678);
      checkOutput("hold_after_release", pcBus.curr_pc, 32'h00000100);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
